pipeline_sequencer: RTL
=======================

Name: pipeline_sequencer

Overview:
- Central control FSM for the four-stage IF/ID/EX/WB datapath.
- Owns start-up, the halt/drain sequence, RAW-hazard interlock and taken-branch flush.
- Drives PC write-enable, the IF/ID hold, and bubble-insert (flush) controls on the IF/ID, ID/EX and EX/WB buffers.
- Branch resolution stays in WB; this block reacts to the resolved redirect.

Parameters:
HALT_OPCODE, 4'hF, opcode that stops fetch and drains the pipe
RT_UNUSED_MASK, 16'h0000, bit n set = opcode n does not read rt (no rt hazard check)
WB_BYPASS, 0, 1 = register file is write-first (no stall on WB match); 0 = stall on WB match
DRAIN_CYCLES, 2, cycles spent in DRAIN before HALTED (EX + WB)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, honoured only in IDLE
opcode_id  in  4  opcode in ID
rs_id  in  6  rs field in ID
rt_id  in  6  rt field in ID
regWrt_ex  in  1  EX-stage instruction writes a register
rd_ex  in  6  EX-stage destination
regWrt_wb  in  1  WB-stage instruction writes a register
rd_wb  in  6  WB-stage destination
branch_taken_wb  in  1  resolved redirect from WB (branchControl)
pc_write  out  1  PC register loads pc_in
ifid_write  out  1  IF/ID loads; 0 = hold
ifid_flush  out  1  IF/ID loads a bubble
idex_flush  out  1  ID/EX loads a bubble (all controls 0)
exwb_flush  out  1  EX/WB loads a bubble
busy  out  1  state is RUN, STALL or DRAIN
done  out  1  state is HALTED
state  out  3  current state encoding
cycle_count  out  32  performance counter (optional feature)
stall_count  out  32  performance counter (optional feature)
flush_count  out  32  performance counter (optional feature)

Behaviour:
- State encoding: IDLE=0, RUN=1, STALL=2, DRAIN=3, HALTED=4.
- State, id_valid and drain counter are registered. Outputs are combinational from state plus current inputs (Mealy), so a stall acts in the same cycle.
- Reset (sampled at edge): state=IDLE, id_valid=0, drain counter=0, counters=0.
- While reset is high, outputs are forced: pc_write=0, ifid_write=0, all flushes=1, busy=0, done=0.
- id_valid: set on an edge where ifid_write=1 and ifid_flush=0; cleared on any edge where ifid_flush=1. Hazard and halt decode are gated by id_valid, so a bubble is never decoded as HALT.
- raw = id_valid & ((regWrt_ex & (rd_ex==rs_id | rt_chk & rd_ex==rt_id)) | (!WB_BYPASS & regWrt_wb & (rd_wb==rs_id | rt_chk & rd_wb==rt_id))).
  - rt_chk = !RT_UNUSED_MASK[opcode_id].
  - No register is exempt.
- halt_id = id_valid & opcode_id==HALT_OPCODE.
- IDLE:
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exwb_flush=1.
  - start=1 -> RUN.
- RUN and STALL, priority highest first:
  1. branch_taken_wb -> pc_write=1, ifid_write=1, ifid_flush=idex_flush=exwb_flush=1; next RUN.
  2. raw -> pc_write=0, ifid_write=0, idex_flush=1, others 0; next STALL.
  3. halt_id -> pc_write=0, ifid_write=0, idex_flush=1; drain counter=DRAIN_CYCLES; next DRAIN.
  4. else -> pc_write=1, ifid_write=1, flushes 0; next RUN.
- DRAIN:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
  - Counter decrements each cycle; counter==1 at edge -> HALTED.
  - branch_taken_wb during DRAIN overrides: redirect outputs as in RUN rule 1, next RUN (halt was wrong-path).
- HALTED:
  - Outputs as IDLE, done=1.
  - start ignored; only reset leaves HALTED.
- start outside IDLE: ignored.
- Simultaneous branch_taken_wb and raw/halt: branch wins; ID instruction is flushed.

Optional Feature:
- Macro PERF_COUNTERS_EN.
- Defined:
  - cycle_count increments every cycle busy=1.
  - stall_count increments every cycle rule 2 fires.
  - flush_count increments every cycle a branch redirect fires.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: all three ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
- Reset 3 cycles then start pulse -> state IDLE (0), pc_write=0, busy=0 during wait; cycle after start: state=1, pc_write=1, ifid_write=1.
- id_valid, rs_id=5, regWrt_ex=1, rd_ex=5, WB_BYPASS=0; next cycle rd_wb=5, regWrt_wb=1 -> 2 stall cycles (pc_write=0, ifid_write=0, idex_flush=1), then RUN; stall_count=2.
- RUN, branch_taken_wb=1 for one cycle -> pc_write=1, all three flushes=1 that cycle; id_valid=0 next cycle; flush_count=1.
- ID holds opcode 4'hF, valid -> DRAIN for 2 cycles, then state=4, done=1, busy=0; start pulse in HALTED -> no change.
- HALT enters DRAIN, branch_taken_wb=1 in first DRAIN cycle -> redirect outputs, state=1, done never asserted.
- Reset asserted mid-STALL -> all flushes=1 immediately, state=IDLE after edge, counters=0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Central control FSM for the IF/ID/EX/WB pipe: start-up, RAW interlock, taken-branch flush, halt/drain.
// Optional performance counters are compiled in with `define PERF_COUNTERS_EN.
module pipeline_sequencer #(
   parameter logic [3:0]  HALT_OPCODE    = 4'hF,
   parameter logic [15:0] RT_UNUSED_MASK = 16'h0000,
   parameter bit          WB_BYPASS      = 1'b0,
   parameter int unsigned DRAIN_CYCLES   = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  opcode_id,
   input  logic [5:0]  rs_id,
   input  logic [5:0]  rt_id,
   input  logic        regWrt_ex,
   input  logic [5:0]  rd_ex,
   input  logic        regWrt_wb,
   input  logic [5:0]  rd_wb,
   input  logic        branch_taken_wb,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exwb_flush,
   output logic        busy,
   output logic        done,
   output logic [2:0]  state,
   output logic [31:0] cycle_count,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_STALL  = 3'd2,
      S_DRAIN  = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   state_t        cur, nxt;
   logic [DW-1:0] drain_cnt, drain_nxt;
   logic          id_valid;
   logic          rt_chk, hit_ex, hit_wb, raw, halt_id;
   logic          redirect, stall_fire;

   // A bubble in ID must never look like a hazard or a HALT.
   assign rt_chk  = !RT_UNUSED_MASK[opcode_id];
   assign hit_ex  = regWrt_ex & ((rd_ex == rs_id) | (rt_chk & (rd_ex == rt_id)));
   assign hit_wb  = !WB_BYPASS & regWrt_wb & ((rd_wb == rs_id) | (rt_chk & (rd_wb == rt_id)));
   assign raw     = id_valid & (hit_ex | hit_wb);
   assign halt_id = id_valid & (opcode_id == HALT_OPCODE);
   assign state   = cur;

   always_comb begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      exwb_flush = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      redirect   = 1'b0;
      stall_fire = 1'b0;
      nxt        = cur;
      drain_nxt  = drain_cnt;
      case (cur)
         S_IDLE: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exwb_flush = 1'b1;
            if (start) nxt = S_RUN;
         end
         S_RUN, S_STALL: begin
            busy = 1'b1;
            if (branch_taken_wb) begin
               redirect = 1'b1;
               nxt      = S_RUN;
            end else if (raw) begin
               stall_fire = 1'b1;
               idex_flush = 1'b1;
               nxt        = S_STALL;
            end else if (halt_id) begin
               idex_flush = 1'b1;
               drain_nxt  = DW'(DRAIN_CYCLES);
               nxt        = S_DRAIN;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               nxt        = S_RUN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            // A WB redirect here means the HALT came from the wrong path.
            if (branch_taken_wb) begin
               redirect  = 1'b1;
               drain_nxt = '0;
               nxt       = S_RUN;
            end else begin
               idex_flush = 1'b1;
               drain_nxt  = drain_cnt - 1'b1;
               if (drain_cnt <= DW'(1)) nxt = S_HALTED;
            end
         end
         S_HALTED: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exwb_flush = 1'b1;
            done       = 1'b1;
         end
         default: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exwb_flush = 1'b1;
            nxt        = S_IDLE;
         end
      endcase

      if (redirect) begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         exwb_flush = 1'b1;
      end

      // Reset acts on the outputs immediately, not only after the edge.
      if (reset) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         exwb_flush = 1'b1;
         busy       = 1'b0;
         done       = 1'b0;
         redirect   = 1'b0;
         stall_fire = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cur       <= S_IDLE;
         drain_cnt <= '0;
         id_valid  <= 1'b0;
      end else begin
         cur       <= nxt;
         drain_cnt <= drain_nxt;
         if (ifid_flush)
            id_valid <= 1'b0;
         else if (ifid_write)
            id_valid <= 1'b1;
      end
   end

`ifdef PERF_COUNTERS_EN
   logic [31:0] cyc_q, stl_q, fls_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_q <= '0;
         stl_q <= '0;
         fls_q <= '0;
      end else begin
         if (busy)       cyc_q <= cyc_q + 32'd1;
         if (stall_fire) stl_q <= stl_q + 32'd1;
         if (redirect)   fls_q <= fls_q + 32'd1;
      end
   end

   assign cycle_count = cyc_q;
   assign stall_count = stl_q;
   assign flush_count = fls_q;
`else
   assign cycle_count = 32'd0;
   assign stall_count = 32'd0;
   assign flush_count = 32'd0;
`endif

endmodule
